xbar_slave_arbiter: RTL

Per-slave-port arbiter and transaction sequencer for the 2x2 cross-bar fabric. It accepts requests from `NUM_MASTERS` masters that decode to one slave and grants one transaction at a time using round-robin priority. It drives the slave request lines from registered state and holds the grant until the slave acks. It then returns a single-cycle ack and registered rdata to the granted master. One instance sits in front of each slave port.

---
 rtl/xbar_slave_arbiter_pkg.sv | 26 ++
 rtl/xbar_slave_arbiter_if.sv | 42 ++++
 rtl/xbar_slave_arbiter_rr_picker.sv | 31 +++
 rtl/xbar_slave_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/xbar_slave_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : xbar_pkg
// Shared types and constants for the crossbar slave-port arbiter.
// Rev     : 1.0
// ----------------------------------------------------------------------------
package xbar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int XBAR_DW = 32;
    localparam int XBAR_AW = 32;

    localparam logic [XBAR_DW-1:0] XBAR_TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Index width that never collapses to zero bits.
    function automatic int xbar_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : xbar_pkg
`default_nettype wire

// File: rtl/xbar_slave_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Interface : xbar_slave_arbiter_if
// Master-side request/response bundle plus slave-side port of one arbiter.
// Rev       : 1.0
// ----------------------------------------------------------------------------
interface xbar_slave_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    import xbar_pkg::*;

    localparam int IDX_W = xbar_idx_w(NUM_MASTERS);

    logic [NUM_MASTERS-1:0]              m_req;
    logic [NUM_MASTERS-1:0][XBAR_AW-1:0] m_addr;
    logic [NUM_MASTERS-1:0]              m_cmd;
    logic [NUM_MASTERS-1:0][XBAR_DW-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]              m_ack;
    logic [XBAR_DW-1:0]                  m_rdata;
    logic                                m_err;
    logic                                s_req;
    logic [XBAR_AW-1:0]                  s_addr;
    logic                                s_cmd;
    logic [XBAR_DW-1:0]                  s_wdata;
    logic                                s_ack;
    logic [XBAR_DW-1:0]                  s_rdata;
    logic [IDX_W-1:0]                    grant_idx;

    // Environment view: requesting masters and the downstream slave.
    modport master (
        output m_req, m_addr, m_cmd, m_wdata, s_ack, s_rdata,
        input  m_ack, m_rdata, m_err, s_req, s_addr, s_cmd, s_wdata, grant_idx
    );

    // Arbiter view.
    modport slave (
        input  m_req, m_addr, m_cmd, m_wdata, s_ack, s_rdata,
        output m_ack, m_rdata, m_err, s_req, s_addr, s_cmd, s_wdata, grant_idx
    );

endinterface : xbar_slave_arbiter_if
`default_nettype wire

// File: rtl/xbar_slave_arbiter_rr_picker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : arb_rr_picker
// Combinational first-requester search starting at ptr_i, wrapping around.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module arb_rr_picker #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       ptr_i,
    output logic                   valid_o,
    output logic [IDX_W-1:0]       idx_o
);
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand    = '0;
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % NUM_MASTERS);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule : arb_rr_picker
`default_nettype wire

// File: rtl/xbar_slave_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : xbar_slave_arbiter
// Round-robin arbiter and transaction sequencer in front of one slave port.
// Optional slave-ack timeout enabled by defining XBAR_ARB_TIMEOUT_EN.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module xbar_slave_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    xbar_slave_arbiter_if.slave bus
);
    import xbar_pkg::*;

    localparam int IDX_W = xbar_idx_w(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("xbar_slave_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t             state_q,   state_d;
    logic [IDX_W-1:0]       rr_ptr_q,  rr_ptr_d;
    logic [IDX_W-1:0]       grant_q,   grant_d;
    logic                   s_req_q,   s_req_d;
    logic                   s_cmd_q,   s_cmd_d;
    logic [XBAR_AW-1:0]     s_addr_q,  s_addr_d;
    logic [XBAR_DW-1:0]     s_wdata_q, s_wdata_d;
    logic [XBAR_DW-1:0]     m_rdata_q, m_rdata_d;
    logic [NUM_MASTERS-1:0] m_ack_q,   m_ack_d;

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic                   timeout_hit;

    arb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req_i   (bus.m_req),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

`ifdef XBAR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m_err_q, m_err_d;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Counter only runs while waiting in BUSY; it is zero on every BUSY entry.
    always_comb begin
        cnt_d   = '0;
        m_err_d = 1'b0;
        if (state_q == BUSY && !bus.s_ack) begin
            if (timeout_hit) begin
                m_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            m_err_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            m_err_q <= m_err_d;
        end
    end

    assign bus.m_err = m_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.m_err   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        s_req_d   = s_req_q;
        s_cmd_d   = s_cmd_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_rdata_d = m_rdata_q;
        m_ack_d   = '0;

        case (state_q)
            IDLE: begin
                m_rdata_d = '0;
                if (pick_valid) begin
                    s_req_d   = 1'b1;
                    s_addr_d  = bus.m_addr[pick_idx];
                    s_cmd_d   = bus.m_cmd[pick_idx];
                    s_wdata_d = bus.m_wdata[pick_idx];
                    grant_d   = pick_idx;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                // A real ack takes precedence over a coincident timeout.
                if (bus.s_ack || timeout_hit) begin
                    s_req_d          = 1'b0;
                    s_cmd_d          = 1'b0;
                    s_addr_d         = '0;
                    s_wdata_d        = '0;
                    m_rdata_d        = bus.s_ack ? bus.s_rdata : XBAR_TIMEOUT_DATA;
                    m_ack_d[grant_q] = 1'b1;
                    state_d          = RESP;
                end
            end
            RESP: begin
                m_rdata_d = '0;
                rr_ptr_d  = (grant_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_q + IDX_W'(1);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            s_req_q   <= 1'b0;
            s_cmd_q   <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_rdata_q <= '0;
            m_ack_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            s_req_q   <= s_req_d;
            s_cmd_q   <= s_cmd_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_rdata_q <= m_rdata_d;
            m_ack_q   <= m_ack_d;
        end
    end

    assign bus.s_req     = s_req_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_cmd     = s_cmd_q;
    assign bus.s_wdata   = s_wdata_q;
    assign bus.m_ack     = m_ack_q;
    assign bus.m_rdata   = m_rdata_q;
    assign bus.grant_idx = grant_q;

endmodule : xbar_slave_arbiter
`default_nettype wire
